// File: rtl/seq_det_prog_if.sv
// Serial-stream and configuration bundle for seq_det_prog.
// Ports: Cfg_load/Pattern/Len/Overlap load the configuration; In_valid/In
// carry the qualified bit stream; Clr clears the counter. Match/Count/Fill
// report back from the detector.
interface seq_det_prog_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CNT_W   = 8
);
  logic               Cfg_load;
  logic [MAX_LEN-1:0] Pattern;
  logic [LEN_W-1:0]   Len;
  logic               Overlap;
  logic               In_valid;
  logic               In;
  logic               Clr;
  logic               Match;
  logic [CNT_W-1:0]   Count;
  logic [LEN_W-1:0]   Fill;

  modport master (
    output Cfg_load, Pattern, Len, Overlap, In_valid, In, Clr,
    input  Match, Count, Fill
  );

  modport slave (
    input  Cfg_load, Pattern, Len, Overlap, In_valid, In, Clr,
    output Match, Count, Fill
  );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with saturating match counter.
// Ports: Clk, Rst (async, active-low), bus (slave side of seq_det_prog_if).
// Pattern[len-1] is the first bit of the sequence, Pattern[0] the last.
// MOORE=0 drives Match combinationally on the completing bit; MOORE=1
// registers it so it appears one cycle later.
module seq_det_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CNT_W   = 8,
  parameter bit          MOORE   = 1'b0
) (
  input  logic          Clk,
  input  logic          Rst,
  seq_det_prog_if.slave bus
);

  // The newest bit is always In itself, so only MAX_LEN-1 bits need storing.
  localparam int unsigned       HIST_W    = MAX_LEN - 1;
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q;

  logic               accept;
  logic               enabled;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic               full;
  logic               hit_c;

  // Next-state for config, history, fill and count.
  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    mask     = '0;

    // A bit presented together with Cfg_load is dropped.
    accept   = bus.In_valid & ~bus.Cfg_load;
    enabled  = (len_q >= LEN_W'(2));
    window   = {hist_q, bus.In};
    // One extra bit so Fill+1 cannot wrap when len sits at 2**LEN_W-1.
    fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
    full     = (fill_inc >= {1'b0, len_q});

    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end

    hit_c = accept & enabled & full & (((window ^ pat_q) & mask) == '0);

    if (bus.Cfg_load) begin
      pat_d  = bus.Pattern;
      len_d  = (bus.Len > MAX_LEN_L) ? MAX_LEN_L : bus.Len;
      ovl_d  = bus.Overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = window[HIST_W-1:0];
      if (!enabled) begin
        fill_d = '0;
      end else if (hit_c && !ovl_q) begin
        // Non-overlapping: a fresh len bits are needed for the next match.
        fill_d = '0;
      end else if (full) begin
        fill_d = len_q;
      end else begin
        fill_d = fill_inc[LEN_W-1:0];
      end
    end

    // Clear wins over a simultaneous hit.
    if (bus.Clr) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset leaves the detector disabled (len = 0).
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= hit_c;
    end
  end

  assign bus.Match = MOORE ? match_q : hit_c;
  assign bus.Count = cnt_q;
  assign bus.Fill  = fill_q;

endmodule
